// File: rtl/rename_free_list.sv
// Physical-register free list for a 4-wide rename stage: compacted allocate, compacted release, one-cycle flush restore.
// Optional consistency checker (in_list bitmap driving fl_err) is enabled with `define FREELIST_CHECK_EN.
module rename_free_list #(
    parameter int PRF_WIDTH = 6,
    parameter int ARCH_REGS = 32,
    parameter int FL_DEPTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 alloc_req,
    output logic                       alloc_ready,
    output logic [PRF_WIDTH-1:0]       alloc_preg0,
    output logic [PRF_WIDTH-1:0]       alloc_preg1,
    output logic [PRF_WIDTH-1:0]       alloc_preg2,
    output logic [PRF_WIDTH-1:0]       alloc_preg3,
    input  logic [3:0]                 rel_valid,
    input  logic [PRF_WIDTH-1:0]       rel_preg0,
    input  logic [PRF_WIDTH-1:0]       rel_preg1,
    input  logic [PRF_WIDTH-1:0]       rel_preg2,
    input  logic [PRF_WIDTH-1:0]       rel_preg3,
    input  logic                       flush,
    output logic [$clog2(FL_DEPTH):0]  free_count,
    output logic                       fl_err
);

    localparam int IDX_W = $clog2(FL_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    logic [PRF_WIDTH-1:0] entry [FL_DEPTH];
    ptr_t                 head, tail, arch_head;
    ptr_t                 head_next, tail_next, arch_head_next;

    logic [2:0]           alloc_off [4];
    logic [2:0]           rel_off   [4];
    logic [2:0]           alloc_cnt, rel_cnt;
    ptr_t                 alloc_ptr [4];
    ptr_t                 rel_ptr   [4];
    logic [IDX_W-1:0]     alloc_idx [4];
    logic [IDX_W-1:0]     rel_idx   [4];
    logic [PRF_WIDTH-1:0] alloc_preg [4];
    logic [PRF_WIDTH-1:0] rel_preg   [4];
    logic                 alloc_fire;

    assign rel_preg[0] = rel_preg0;
    assign rel_preg[1] = rel_preg1;
    assign rel_preg[2] = rel_preg2;
    assign rel_preg[3] = rel_preg3;

    // Prefix popcounts compact the requesting slots onto consecutive list entries.
    always_comb begin
        alloc_cnt = '0;
        rel_cnt   = '0;
        for (int i = 0; i < 4; i++) begin
            alloc_off[i] = alloc_cnt;
            rel_off[i]   = rel_cnt;
            alloc_cnt    = alloc_cnt + {2'b00, alloc_req[i]};
            rel_cnt      = rel_cnt + {2'b00, rel_valid[i]};
            alloc_ptr[i] = head + ptr_t'(alloc_off[i]);
            rel_ptr[i]   = tail + ptr_t'(rel_off[i]);
            alloc_idx[i] = alloc_ptr[i][IDX_W-1:0];
            rel_idx[i]   = rel_ptr[i][IDX_W-1:0];
            alloc_preg[i] = entry[alloc_idx[i]];
        end
    end

    assign alloc_preg0 = alloc_preg[0];
    assign alloc_preg1 = alloc_preg[1];
    assign alloc_preg2 = alloc_preg[2];
    assign alloc_preg3 = alloc_preg[3];

    assign free_count  = tail - head;
    assign alloc_ready = (free_count >= ptr_t'(4));
    assign alloc_fire  = (|alloc_req) && alloc_ready && !flush;

    always_comb begin
        tail_next      = tail + ptr_t'(rel_cnt);
        arch_head_next = arch_head + ptr_t'(rel_cnt);
        head_next      = head;
        if (flush)
            head_next = arch_head_next;
        else if (alloc_fire)
            head_next = head + ptr_t'(alloc_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            arch_head <= '0;
            tail      <= ptr_t'(FL_DEPTH);
            for (int i = 0; i < FL_DEPTH; i++)
                entry[i] <= PRF_WIDTH'(ARCH_REGS + i);
        end else begin
            head      <= head_next;
            arch_head <= arch_head_next;
            tail      <= tail_next;
            for (int i = 0; i < 4; i++)
                if (rel_valid[i])
                    entry[rel_idx[i]] <= rel_preg[i];
        end
    end

`ifdef FREELIST_CHECK_EN
    localparam int NUM_PREGS = 2 ** PRF_WIDTH;

    logic [NUM_PREGS-1:0] in_list, in_list_next;
    logic                 err_q, err_next;
    ptr_t                 spec_cnt;
    logic [IDX_W-1:0]     off;

    always_comb begin
        in_list_next = in_list;
        err_next     = err_q;
        spec_cnt     = head - arch_head_next;
        off          = '0;
        // Flush hands the speculatively allocated window back to the list.
        if (flush) begin
            for (int k = 0; k < FL_DEPTH; k++) begin
                off = IDX_W'(k) - arch_head_next[IDX_W-1:0];
                if (ptr_t'(off) < spec_cnt)
                    in_list_next[entry[k]] = 1'b1;
            end
        end
        if (alloc_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (alloc_req[i]) begin
                    if (!in_list[alloc_preg[i]])
                        err_next = 1'b1;
                    in_list_next[alloc_preg[i]] = 1'b0;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (rel_valid[i]) begin
                if (in_list[rel_preg[i]])
                    err_next = 1'b1;
                for (int j = 0; j < i; j++)
                    if (rel_valid[j] && (rel_preg[j] == rel_preg[i]))
                        err_next = 1'b1;
                in_list_next[rel_preg[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
            for (int b = 0; b < NUM_PREGS; b++)
                in_list[b] <= (b >= ARCH_REGS);
        end else begin
            err_q   <= err_next;
            in_list <= in_list_next;
        end
    end

    assign fl_err = err_q;
`else
    assign fl_err = 1'b0;
`endif

endmodule

// File: tb/tb_rename_free_list.sv
// Directed scoreboard bench for rename_free_list: expected values are queued as stimulus is driven and popped at each check.
module tb_rename_free_list;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] alloc_req;
    logic       alloc_ready;
    logic [5:0] alloc_preg0, alloc_preg1, alloc_preg2, alloc_preg3;
    logic [3:0] rel_valid;
    logic [5:0] rel_preg0, rel_preg1, rel_preg2, rel_preg3;
    logic       flush;
    logic [5:0] free_count;
    logic       fl_err;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_q[$];

    rename_free_list dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_req   (alloc_req),
        .alloc_ready (alloc_ready),
        .alloc_preg0 (alloc_preg0),
        .alloc_preg1 (alloc_preg1),
        .alloc_preg2 (alloc_preg2),
        .alloc_preg3 (alloc_preg3),
        .rel_valid   (rel_valid),
        .rel_preg0   (rel_preg0),
        .rel_preg1   (rel_preg1),
        .rel_preg2   (rel_preg2),
        .rel_preg3   (rel_preg3),
        .flush       (flush),
        .free_count  (free_count),
        .fl_err      (fl_err)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req = 4'b0000;
        rel_valid = 4'b0000;
        rel_preg0 = '0; rel_preg1 = '0; rel_preg2 = '0; rel_preg3 = '0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic expect_val(input int v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input int obs);
        int exp_v;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=<empty scoreboard>", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
            end
        end
    endtask

    task automatic release4(input logic [3:0] v, input int p0, input int p1, input int p2, input int p3);
        rel_valid = v;
        rel_preg0 = 6'(p0); rel_preg1 = 6'(p1); rel_preg2 = 6'(p2); rel_preg3 = 6'(p3);
    endtask

    initial begin
        rst = 1'b0;
        idle();

        // Reset state and a full-width allocation.
        do_reset();
        #2;
        expect_val(32); chk("reset_free_count", free_count);
        expect_val(1);  chk("reset_alloc_ready", alloc_ready);
        expect_val(0);  chk("reset_fl_err", fl_err);
        alloc_req = 4'b1111;
        #1;
        expect_val(32); expect_val(33); expect_val(34); expect_val(35);
        chk("a1111_slot0", alloc_preg0);
        chk("a1111_slot1", alloc_preg1);
        chk("a1111_slot2", alloc_preg2);
        chk("a1111_slot3", alloc_preg3);
        cycle();
        idle();
        #1;
        expect_val(28); chk("a1111_free_count", free_count);

        // Sparse request compacts onto consecutive entries.
        do_reset();
        alloc_req = 4'b1010;
        #2;
        expect_val(32); expect_val(33);
        chk("a1010_slot1", alloc_preg1);
        chk("a1010_slot3", alloc_preg3);
        cycle();
        idle();
        #1;
        expect_val(30); chk("a1010_free_count", free_count);

        // Drain to empty, stall, then refill across the wrap point.
        do_reset();
        alloc_req = 4'b1111;
        for (int i = 0; i < 8; i++) cycle();
        #1;
        expect_val(0); chk("empty_free_count", free_count);
        expect_val(0); chk("empty_alloc_ready", alloc_ready);
        cycle();
        idle();
        #1;
        expect_val(0);  chk("stall_free_count", free_count);
        expect_val(32); chk("stall_head_slot0", alloc_preg0);
        release4(4'b0011, 5, 9, 0, 0);
        cycle();
        idle();
        #1;
        expect_val(2); chk("rel2_free_count", free_count);
        expect_val(0); chk("rel2_alloc_ready", alloc_ready);
        release4(4'b0011, 12, 20, 0, 0);
        cycle();
        idle();
        #1;
        expect_val(1); chk("rel4_alloc_ready", alloc_ready);
        alloc_req = 4'b1111;
        #1;
        expect_val(5); expect_val(9); expect_val(12); expect_val(20);
        chk("wrap_slot0", alloc_preg0);
        chk("wrap_slot1", alloc_preg1);
        chk("wrap_slot2", alloc_preg2);
        chk("wrap_slot3", alloc_preg3);
        cycle();
        idle();
        #1;
        expect_val(0); chk("wrap_free_count", free_count);

        // Speculative allocations are returned by a flush.
        do_reset();
        alloc_req = 4'b1111;
        cycle();
        cycle();
        idle();
        release4(4'b1111, 1, 2, 3, 4);
        cycle();
        idle();
        flush = 1'b1;
        alloc_req = 4'b1111;
        cycle();
        idle();
        #1;
        expect_val(32); chk("flush_free_count", free_count);
        expect_val(1);  chk("flush_alloc_ready", alloc_ready);
        alloc_req = 4'b1111;
        #1;
        expect_val(36); expect_val(37); expect_val(38); expect_val(39);
        chk("flush_slot0", alloc_preg0);
        chk("flush_slot1", alloc_preg1);
        chk("flush_slot2", alloc_preg2);
        chk("flush_slot3", alloc_preg3);
        cycle();
        idle();
        #1;
        expect_val(0); chk("flush_fl_err", fl_err);

        // Simultaneous allocate and release at free_count = 4.
        do_reset();
        alloc_req = 4'b1111;
        for (int i = 0; i < 7; i++) cycle();
        #1;
        expect_val(4); chk("pre_both_free_count", free_count);
        release4(4'b1111, 10, 11, 12, 13);
        #1;
        expect_val(60); expect_val(63);
        chk("both_slot0", alloc_preg0);
        chk("both_slot3", alloc_preg3);
        cycle();
        rel_valid = 4'b0000;
        #1;
        expect_val(4);  chk("both_free_count", free_count);
        expect_val(10); expect_val(11); expect_val(12); expect_val(13);
        chk("after_both_slot0", alloc_preg0);
        chk("after_both_slot1", alloc_preg1);
        chk("after_both_slot2", alloc_preg2);
        chk("after_both_slot3", alloc_preg3);
        idle();

        // Reset in the middle of activity wins over flush/alloc/release.
        alloc_req = 4'b1111;
        release4(4'b0001, 7, 0, 0, 0);
        flush = 1'b1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle();
        #1;
        expect_val(32); chk("rst_busy_free_count", free_count);
        expect_val(32); chk("rst_busy_slot0", alloc_preg0);

        // Releasing a register that is already free.
        do_reset();
        release4(4'b0001, 40, 0, 0, 0);
        cycle();
        idle();
        #1;
`ifdef FREELIST_CHECK_EN
        expect_val(1); chk("dup_rel_fl_err", fl_err);
        cycle();
        cycle();
        #1;
        expect_val(1); chk("dup_rel_fl_err_sticky", fl_err);
`else
        expect_val(0); chk("nochk_fl_err", fl_err);
`endif
        do_reset();
        #1;
        expect_val(0); chk("fl_err_after_rst", fl_err);

        if (exp_q.size() != 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_drain: observed=%0d leftover expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rename_free_list.md
Name: rename_free_list

Overview:
- Physical-register free list for the 4-wide rename stage.
- Supplies up to 4 free physical register numbers per cycle, in program order, to the rename stage's destination-register (prd) slots.
- Reclaims up to 4 stale mappings (preprd) per cycle from ROB commit.
- Keeps an architectural head pointer so the speculative head can be restored in one cycle on pipeline flush.

Parameters:
- PRF_WIDTH, 6, physical register index width (64 physical registers).
- ARCH_REGS, 32, architectural registers. Physical 0..31 are mapped at reset.
- FL_DEPTH, 32, free-list entries (2^PRF_WIDTH - ARCH_REGS). Must be a power of two.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- alloc_req  in  4  per-slot allocation request; bit i = instr i writes an rd
- alloc_ready  out  1  at least 4 entries free; allocation accepted this cycle
- alloc_preg0..alloc_preg3  out  6 each  physical reg assigned to slot 0..3 (valid only where alloc_req[i]=1)
- rel_valid  in  4  per-slot commit release
- rel_preg0..rel_preg3  in  6 each  stale physical reg returned by committing instr 0..3
- flush  in  1  pipeline flush; restore speculative head to architectural head
- free_count  out  6  number of free entries (0..32)
- fl_err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Storage: FL_DEPTH x PRF_WIDTH circular array.
- Pointers: head, tail, arch_head, each log2(FL_DEPTH)+1 bits (index plus wrap bit).
- free_count = tail - head, modulo 2^(log2(FL_DEPTH)+1). It is registered-state derived and combinational to the output.
- Reset values:
  - entry[i] = ARCH_REGS + i (32..63)
  - head = 0, arch_head = 0, tail = 6'b100000, so free_count = 32
  - alloc_ready = 1, fl_err = 0
- Allocation:
  - alloc_ready = (free_count >= 4). It depends only on current state, never on this cycle's releases.
  - alloc_fire = |alloc_req & alloc_ready & ~flush.
  - Slots are compacted: slot i reads entry[head + popcount(alloc_req[i-1:0])].
  - alloc_preg outputs are combinational from the array and head (zero-latency, same-cycle read; rename writes the RAT on the next edge).
  - On fire, head advances by popcount(alloc_req) at the clock edge.
  - Slots with alloc_req[i]=0 output the value slot i would read; rename must ignore them.
  - If ~alloc_ready, head holds and upstream must stall the whole group. Partial groups are never accepted.
- Release:
  - Always accepted, no handshake.
  - Compacted write: entry[tail + popcount(rel_valid[i-1:0])] <= rel_preg_i; tail advances by popcount(rel_valid).
  - arch_head advances by popcount(rel_valid) in the same cycle. Each committing instr that released a preprd had allocated one entry at rename.
  - Overflow is impossible by construction (at most 32 free).
- Simultaneous alloc and release: free_count_next = free_count - popcount(alloc_req)*alloc_fire + popcount(rel_valid). Entries released this cycle become allocatable next cycle.
- Flush:
  - head <= arch_head_next, where arch_head_next includes the same-cycle release advance.
  - The allocation is dropped. Releases in the flush cycle still complete.
  - The free list returns to the committed state in 1 cycle. alloc_ready reflects the restored count on the next cycle.
- Wrap-around: all pointer arithmetic wraps modulo 2*FL_DEPTH. Index = low log2(FL_DEPTH) bits.
- rst during activity: all state returns to reset values on that edge. flush/alloc/rel in the same cycle are ignored.

Optional Feature:
- Macro FREELIST_CHECK_EN.
- Defined:
  - Adds a 64-bit in_list bitmap; reset value is bits 32..63 set.
  - Alloc fire clears the bit for each allocated preg. Release sets the bit for each released preg.
  - fl_err sets (sticky until rst) on any of:
    - release of a preg whose bit is already set
    - release of the same preg twice in one cycle
    - allocation of a preg whose bit is clear
  - On flush the bitmap is rebuilt by setting bits for entries between arch_head and head.
- Not defined: no bitmap; fl_err tied to 0.

Test Plan:
- Reset, then alloc_req=4'b1111 -> alloc_preg0..3 = 32,33,34,35; next cycle free_count=28.
- alloc_req=4'b1010 right after reset -> slot1=32, slot3=33; free_count=30 next cycle.
- Eight 4-wide allocs from reset -> free_count=0, alloc_ready=0; further alloc_req=4'b1111 leaves head unchanged. Then rel_valid=4'b0011 with pregs 5,9 -> free_count=2, still not ready. Then release 2 more (12,20) -> ready, next alloc gives 5,9,12,20 (wrap-around).
- Alloc 8 (32..39), commit-release 4 (pregs 1..4), then flush -> free_count = 32 - 8 + 4 + 4 = 32. Next alloc returns 36,37,38,39.
- Same cycle: alloc 4'b1111 and release 4'b1111 at free_count=4 -> free_count stays 4; released pregs appear after existing entries.
- With FREELIST_CHECK_EN: release preg 40 while still free -> fl_err=1 next cycle, and stays 1 until rst.
